timer_ctrl_8bit: RTL and testbench
==================================

TIMER_CTRL_8BIT -- requirements
Module: timer_ctrl_8bit

Interface
REQ-001 The block SHALL expose the ports below; all inputs SHALL be synchronous to clk except reset.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  start, or resume after a pause.
REQ-005 stop  input  1  pause when running; abort when paused.
REQ-006 load  input  1  write load_val into the reload register.
REQ-007 load_val  input  8  reload value N (unsigned).
REQ-008 mode  input  1  0 = one-shot, 1 = auto-reload; sampled on every terminal-count edge.
REQ-009 irq_clr  input  1  clears irq.
REQ-010 count  output  8  current counter value (registered).
REQ-011 tc  output  1  terminal-count pulse (registered, one cycle).
REQ-012 irq  output  1  sticky interrupt flag.
REQ-013 busy  output  1  high in RUN or PAUSE.
REQ-014 state  output  2  encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-015 The block SHALL contain an 8-bit reload register rl and an 8-bit down-counter count sequenced by a 4-state FSM (IDLE, RUN, PAUSE, DONE).
REQ-016 load=1 SHALL write rl<=load_val at the edge in any state; it SHALL NOT alter count, and the new value SHALL apply only at the next reload.
REQ-017 IDLE/DONE + start, rl!=0: count<=rl, state->RUN; rl==0: start ignored, state unchanged.
REQ-018 load and start at the same edge SHALL reload from the old rl.
REQ-019 RUN, count>1, no stop: count<=count-1 each edge.
REQ-020 RUN, count==1, no stop: tc<=1; mode=0 -> count<=0, state->DONE; mode=1 -> count<=rl, stay RUN.
REQ-021 In mode=1, if rl==0 when a reload is due, count SHALL be set to 0 and state SHALL go to DONE (no wrap to 255).
REQ-022 The first tc SHALL be high in the cycle following the Nth edge after the start edge; the auto-reload period SHALL be exactly N cycles, with no idle cycle between periods.
REQ-023 tc SHALL be high for exactly one cycle per terminal count and low otherwise.
REQ-024 RUN + stop: state->PAUSE, count held. stop SHALL take priority over decrement, including when count==1 (no tc is generated).
REQ-025 PAUSE + start (no stop): state->RUN, resuming from the held count without reload.
REQ-026 PAUSE + stop: count<=0, state->IDLE, no tc.
REQ-027 start and stop asserted together: stop SHALL win in every state; in IDLE/DONE both SHALL be ignored.
REQ-028 start in RUN SHALL be ignored (no restart).
REQ-029 DONE: count holds 0; start behaves as in IDLE.
REQ-030 irq SHALL be set on any edge where tc is set and cleared by irq_clr; set and clear at the same edge SHALL leave irq=1.
REQ-031 busy SHALL be derived from the registered state only (no combinational path from inputs).
REQ-032 Counter arithmetic SHALL be 8-bit unsigned; count SHALL never underflow below 0.

Reset
REQ-033 reset=1 SHALL immediately force count=0, rl=0, tc=0, irq=0, state=IDLE, busy=0, independent of clk.
REQ-034 Reset asserted mid-RUN SHALL abort the run with no tc; after release the block SHALL require load and start to run again.
REQ-035 The first edge after reset deassertion SHALL process inputs normally.

Verification
REQ-036 One-shot: load_val=5, load; mode=0, start -> count 5,4,3,2,1,0; tc high for 1 cycle 5 cycles after start; state=DONE; irq=1; busy=0.
REQ-037 Auto-reload: rl=3, mode=1, start -> tc every 3 cycles; count sequence 3,2,1,3,2,1...; switching mode to 0 -> ends in DONE at the next terminal count.
REQ-038 Pause/resume: rl=10, start, stop at count=6 -> count holds 6 for 4 cycles; start -> 5,4,...; tc fires 6 cycles after resume; stop twice -> IDLE, count=0.
REQ-039 Priority: start and stop at the same edge in RUN -> PAUSE; stop exactly when count==1 -> PAUSE with count=1 and no tc; irq_clr coincident with tc -> irq stays 1.
REQ-040 Edge cases: start with rl=0 -> stays IDLE; rl=255 one-shot -> tc after 255 cycles; load 7 during RUN (rl=4) -> current period ends at 4 cycles, next period is 7.
REQ-041 Reset: assert reset asynchronously mid-RUN (count=2) -> all outputs 0 before the next edge; no tc after release.

Source files
------------

// File: rtl/timer_ctrl_8bit.sv
// 8-bit down-counting timer with reload register, one-shot/auto-reload modes,
// pause/resume/abort control and a sticky interrupt raised on terminal count.
module timer_ctrl_8bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       mode,
    input  logic       irq_clr,
    output logic [7:0] count,
    output logic       tc,
    output logic       irq,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     st_q, st_d;
    logic [7:0] rl;
    logic [7:0] cnt_d;
    logic       tc_d;

    // rl updates alongside the FSM, so a same-edge start/reload still sees the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= IDLE;
            count <= 8'd0;
            rl    <= 8'd0;
            tc    <= 1'b0;
            irq   <= 1'b0;
        end else begin
            st_q  <= st_d;
            count <= cnt_d;
            tc    <= tc_d;
            irq   <= tc_d | (irq & ~irq_clr);
            if (load)
                rl <= load_val;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = count;
        tc_d  = 1'b0;
        case (st_q)
            IDLE, DONE: begin
                if (start && !stop && rl != 8'd0) begin
                    cnt_d = rl;
                    st_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    st_d = PAUSE;
                end else if (count > 8'd1) begin
                    cnt_d = count - 8'd1;
                end else begin
                    // terminal count; an empty reload register ends the run instead of wrapping
                    tc_d = 1'b1;
                    if (mode && rl != 8'd0) begin
                        cnt_d = rl;
                    end else begin
                        cnt_d = 8'd0;
                        st_d  = DONE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    cnt_d = 8'd0;
                    st_d  = IDLE;
                end else if (start) begin
                    st_d = RUN;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    assign state = st_q;
    assign busy  = (st_q == RUN) || (st_q == PAUSE);

endmodule

// File: tb/tb_timer_ctrl_8bit.sv
// Self-checking bench for timer_ctrl_8bit: vector table, directed corner-case
// sequences and randomized traffic compared with a rule-level reference model.
module tb_timer_ctrl_8bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, load, mode, irq_clr;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, irq, busy;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cur_mode = 0;
    bit use_model = 0;

    // reference model state (0 idle, 1 run, 2 pause, 3 done)
    int m_st, m_cnt, m_rl, m_tc, m_irq;

    timer_ctrl_8bit dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .mode(mode), .irq_clr(irq_clr),
        .count(count), .tc(tc), .irq(irq), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, ld;
        logic [7:0] lv;
        logic       md, clr;
        int         e_cnt;
        logic       e_tc, e_irq;
        int         e_st;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input int e_cnt, input int e_tc, input int e_irq, input int e_st);
        chk({nm, ".count"}, int'(count), e_cnt);
        chk({nm, ".tc"}, int'(tc), e_tc);
        chk({nm, ".irq"}, int'(irq), e_irq);
        chk({nm, ".state"}, int'(state), e_st);
        chk({nm, ".busy"}, int'(busy), (e_st == 1 || e_st == 2) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_rl = 0; m_tc = 0; m_irq = 0;
    endtask

    // Rules applied in priority order: stop, start, counting; load lands after.
    task automatic model_edge(input int st, input int sp, input int ld, input int lv, input int md, input int clr);
        int ns, nc, ntc;
        ns = m_st; nc = m_cnt; ntc = 0;
        if (sp && m_st == 1) begin
            ns = 2;
        end else if (sp && m_st == 2) begin
            ns = 0; nc = 0;
        end else if (!sp && st && (m_st == 0 || m_st == 3)) begin
            if (m_rl != 0) begin ns = 1; nc = m_rl; end
        end else if (!sp && st && m_st == 2) begin
            ns = 1;
        end else if (!sp && m_st == 1) begin
            if (m_cnt >= 2) nc = m_cnt - 1;
            else begin
                ntc = 1;
                if (md != 0 && m_rl != 0) nc = m_rl;
                else begin nc = 0; ns = 3; end
            end
        end
        m_irq = (ntc != 0 || (m_irq != 0 && clr == 0)) ? 1 : 0;
        m_st = ns; m_cnt = nc; m_tc = ntc;
        if (ld) m_rl = lv;
    endtask

    task automatic step(input logic st, input logic sp, input logic ld, input logic [7:0] lv,
                        input logic md, input logic clr);
        @(negedge clk);
        start = st; stop = sp; load = ld; load_val = lv; mode = md; irq_clr = clr;
        @(posedge clk);
        if (!reset) model_edge(st, sp, ld, lv, md, clr);
        #1;
        if (use_model) chk_all("model", m_cnt, m_tc, m_irq, m_st);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 8'd0, cur_mode[0], 1'b0);
    endtask

    task automatic run_until_tc(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            idle_step();
            if (tc) begin n = i; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 0; stop = 0; load = 0; load_val = 0; mode = 0; irq_clr = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 0; stop = 0; load = 0; load_val = 0; mode = 0; irq_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // one-shot of 5, then same-edge load/start, pause/abort, start with rl=0
        tbl[0]  = '{0,0,1,8'd5,0,0, 0,0,0,0};
        tbl[1]  = '{1,0,0,8'd0,0,0, 5,0,0,1};
        tbl[2]  = '{0,0,0,8'd0,0,0, 4,0,0,1};
        tbl[3]  = '{0,0,0,8'd0,0,0, 3,0,0,1};
        tbl[4]  = '{0,0,0,8'd0,0,0, 2,0,0,1};
        tbl[5]  = '{0,0,0,8'd0,0,0, 1,0,0,1};
        tbl[6]  = '{0,0,0,8'd0,0,0, 0,1,1,3};
        tbl[7]  = '{0,0,0,8'd0,0,0, 0,0,1,3};
        tbl[8]  = '{0,0,0,8'd0,0,1, 0,0,0,3};
        tbl[9]  = '{1,1,0,8'd0,0,0, 0,0,0,3};
        tbl[10] = '{1,0,1,8'd0,0,0, 5,0,0,1};
        tbl[11] = '{0,1,0,8'd0,0,0, 5,0,0,2};
        tbl[12] = '{0,1,0,8'd0,0,0, 0,0,0,0};
        tbl[13] = '{1,0,0,8'd0,0,0, 0,0,0,0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].ld, tbl[i].lv, tbl[i].md, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, int'(tbl[i].e_tc), int'(tbl[i].e_irq), tbl[i].e_st);
        end

        use_model = 1;

        // auto-reload period 3, then switch to one-shot
        do_reset();
        cur_mode = 1;
        step(0, 0, 1, 8'd3, 1, 0);
        step(1, 0, 0, 8'd0, 1, 0);
        chk("ar.start_cnt", int'(count), 3);
        for (int k = 0; k < 3; k++) begin
            run_until_tc(10, n);
            chk($sformatf("ar.period%0d", k), n, 3);
        end
        cur_mode = 0;
        run_until_tc(10, n);
        chk("ar.last_period", n, 3);
        chk("ar.done", int'(state), 3);

        // reload value changed mid-period applies only to the next period
        do_reset();
        cur_mode = 1;
        step(0, 0, 1, 8'd4, 1, 0);
        step(1, 0, 0, 8'd0, 1, 0);
        step(0, 0, 1, 8'd7, 1, 0);
        run_until_tc(20, n);
        chk("ld.period_old", n + 1, 4);
        run_until_tc(20, n);
        chk("ld.period_new", n, 7);

        // pause at 6, hold, resume, then stop twice
        do_reset();
        cur_mode = 0;
        step(0, 0, 1, 8'd10, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0);
        repeat (4) idle_step();
        chk("pr.at6", int'(count), 6);
        step(0, 1, 0, 8'd0, 0, 0);
        repeat (4) idle_step();
        chk("pr.hold_cnt", int'(count), 6);
        chk("pr.hold_st", int'(state), 2);
        step(1, 0, 0, 8'd0, 0, 0);
        run_until_tc(20, n);
        chk("pr.resume_tc", n, 6);
        step(1, 0, 0, 8'd0, 0, 0);
        step(0, 1, 0, 8'd0, 0, 0);
        step(0, 1, 0, 8'd0, 0, 0);
        chk("pr.abort_st", int'(state), 0);
        chk("pr.abort_cnt", int'(count), 0);

        // priority: start+stop in RUN, stop at count 1, irq_clr together with tc
        do_reset();
        step(0, 0, 1, 8'd2, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0);
        step(1, 1, 0, 8'd0, 0, 0);
        chk("pri.ss_pause", int'(state), 2);
        step(1, 0, 0, 8'd0, 0, 0);
        idle_step();
        chk("pri.cnt1", int'(count), 1);
        step(0, 1, 0, 8'd0, 0, 0);
        chk("pri.stop1_st", int'(state), 2);
        chk("pri.stop1_cnt", int'(count), 1);
        chk("pri.stop1_tc", int'(tc), 0);
        step(1, 0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 8'd0, 0, 1);
        chk("pri.clr_tc", int'(tc), 1);
        chk("pri.clr_irq", int'(irq), 1);

        // rl=255 one-shot
        do_reset();
        step(0, 0, 1, 8'd255, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0);
        run_until_tc(300, n);
        chk("max.tc_after", n, 255);

        // asynchronous reset with count at 2
        do_reset();
        step(0, 0, 1, 8'd5, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0);
        repeat (3) idle_step();
        chk("ar_rst.pre_cnt", int'(count), 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 8'd0, 0, 0);
            chk("post_rst.tc", int'(tc), 0);
        end
        chk("post_rst.idle", int'(state), 0);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic [7:0] lv;
            lv = 8'($urandom_range(0, 9));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                 lv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
